// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// (IF) port and the load/store (LS) port. One transaction is in flight at a
// time. The memory port is driven from registers; read data is returned to
// the owner of the transaction after a fixed latency.
//
// Handshake: a requester raises *_req and holds it (and its address/data)
// stable until it sees *_ready high in the same cycle; the transfer happens
// on that rising edge. *_ready is only ever high in IDLE, and at most one of
// if_ready / ls_ready is high. *_rvalid is a one-cycle pulse with *_rdata
// valid in that cycle; it has no back-pressure.
//
// Optional build macro: MEM_ARB_BYPASS_EN
//   undefined : response registered, rvalid in a separate RESP cycle
//   defined   : RESP removed, rvalid/rdata forwarded from mem_rdata in the
//               last WAIT cycle
//
// Ports:
//   clock, reset           clock (rising edge), synchronous active-high reset
//   if_req/if_addr         fetch request (always a full-word read)
//   if_ready/if_rvalid/if_rdata   fetch accept, response pulse, response data
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be   load/store request
//   ls_ready/ls_rvalid/ls_rdata   load/store accept, load response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata   memory port
//   busy                   high whenever the FSM is not in IDLE
//   dbg_state              current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 RESP)
//   dbg_starve_cnt         consecutive LS grants while IF was waiting
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int SC_W        = $clog2(STARVE_LIMIT + 1),
    localparam int WC_W        = $clog2(MEM_LATENCY + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_be,
    output logic                  ls_ready,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [1:0]            dbg_state,
    output logic [SC_W-1:0]       dbg_starve_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  owner_ls_q;     // 1 = LS owns the transaction
    logic [WC_W-1:0]       wait_cnt_q;
    logic [SC_W-1:0]       starve_cnt_q;
    logic [SC_W-1:0]       starve_cnt_d;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W/8-1:0]   mem_be_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic [DATA_W-1:0]     ls_rdata_q;
`ifndef MEM_ARB_BYPASS_EN
    logic                  if_rvalid_q;
    logic                  ls_rvalid_q;
`endif

    logic is_idle;
    logic force_if;
    logic if_grant;
    logic ls_grant;
    logic last_wait;

    assign is_idle   = (state_q == S_IDLE);
    // IF has waited through STARVE_LIMIT LS grants: it wins the next tie.
    assign force_if  = (starve_cnt_q == SC_W'(STARVE_LIMIT)) && if_req;
    assign ls_grant  = is_idle && ls_req && !force_if;
    assign if_grant  = is_idle && if_req && (!ls_req || force_if);
    assign last_wait = (state_q == S_WAIT) && (wait_cnt_q == '0);

    // Starvation counter only moves in IDLE; it counts LS wins over a
    // pending fetch and saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (is_idle) begin
            if (if_grant || !if_req) begin
                starve_cnt_d = '0;
            end else if (ls_grant && (starve_cnt_q != SC_W'(STARVE_LIMIT))) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_ls_q   <= 1'b0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
`ifndef MEM_ARB_BYPASS_EN
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
`endif
        end else begin
            starve_cnt_q <= starve_cnt_d;
            // Strobes are single-cycle unless a grant re-arms them below.
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
`ifndef MEM_ARB_BYPASS_EN
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (ls_grant) begin
                        owner_ls_q  <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= ls_we;
                        mem_addr_q  <= ls_addr;
                        mem_wdata_q <= ls_wdata;
                        mem_be_q    <= ls_be;
                        state_q     <= S_ISSUE;
                    end else if (if_grant) begin
                        // Fetches are full-word reads; write data is left as is.
                        owner_ls_q  <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_be_q    <= '1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mem_we_q still holds this transaction's direction here.
                    if (mem_we_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= WC_W'(MEM_LATENCY - 1);
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (last_wait) begin
                        if (owner_ls_q) begin
                            ls_rdata_q <= mem_rdata;
                        end else begin
                            if_rdata_q <= mem_rdata;
                        end
`ifdef MEM_ARB_BYPASS_EN
                        state_q <= S_IDLE;
`else
                        if_rvalid_q <= !owner_ls_q;
                        ls_rvalid_q <= owner_ls_q;
                        state_q     <= S_RESP;
`endif
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ready       = if_grant;
    assign ls_ready       = ls_grant;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign busy           = !is_idle;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

`ifdef MEM_ARB_BYPASS_EN
    // Response forwarded straight from the memory in the capture cycle,
    // then held from the register until the next capture.
    assign if_rvalid = last_wait && !owner_ls_q;
    assign ls_rvalid = last_wait && owner_ls_q;
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;
`else
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter with MEM_LATENCY=2, STARVE_LIMIT=4. A simple
// memory model returns a fixed function of the address MEM_LATENCY cycles
// after mem_en and garbage otherwise. Read responses are predicted at
// acceptance time (cycle and data) and compared when rvalid pulses.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int L    = 2;
    localparam int SL   = 4;
    localparam int SC_W = $clog2(SL + 1);
`ifdef MEM_ARB_BYPASS_EN
    localparam int RESP_LAT = L + 1;   // acceptance to rvalid
    localparam int OCC      = L + 2;   // read occupancy
`else
    localparam int RESP_LAT = L + 2;
    localparam int OCC      = L + 3;
`endif

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              if_req, if_ready, if_rvalid;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              ls_req, ls_we, ls_ready, ls_rvalid;
    logic [AW-1:0]     ls_addr;
    logic [DW-1:0]     ls_wdata, ls_rdata;
    logic [DW/8-1:0]   ls_be;
    logic              mem_en, mem_we, busy;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic [DW/8-1:0]   mem_be;
    logic [1:0]        dbg_state;
    logic [SC_W-1:0]   dbg_starve_cnt;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    logic [31:0] pipe [L];
    always @(posedge clock) begin
        pipe[0] <= mem_en ? mem_model(mem_addr) : (32'hBAD0_0000 | cyc[15:0]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] if_exp_q[$];   // {expected rvalid cycle, expected data}
    logic [63:0] ls_exp_q[$];
    logic [31:0] last_addr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (if_rvalid) begin
                if (if_exp_q.size() == 0) begin
                    chk("if_unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = if_exp_q.pop_front();
                    chk("if_rvalid_cycle", 64'(cyc), {32'd0, e[63:32]});
                    chk("if_rdata", 64'(if_rdata), {32'd0, e[31:0]});
                end
            end
            if (ls_rvalid) begin
                if (ls_exp_q.size() == 0) begin
                    chk("ls_unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = ls_exp_q.pop_front();
                    chk("ls_rvalid_cycle", 64'(cyc), {32'd0, e[63:32]});
                    chk("ls_rdata", 64'(ls_rdata), {32'd0, e[31:0]});
                end
            end
        end
    end

    // ---------------- stimulus records / drivers ----------------
    typedef struct {
        bit          is_ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } txn_t;

    function automatic txn_t mk(input bit is_ls, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        txn_t t;
        t.is_ls = is_ls; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
        t.exp_rdata = (is_ls && we) ? 32'h0 : mem_model(addr);
        return t;
    endfunction

    // Raises the request at the current cycle (caller is at posedge+1),
    // waits for ready, checks the issue cycle, returns at acceptance+2.
    task automatic do_txn(input txn_t t, output int acc_cyc, output int waited);
        bit got;
        got = 0; waited = 0; acc_cyc = -1;
        if (t.is_ls) begin
            ls_we = t.we; ls_addr = t.addr; ls_wdata = t.wdata; ls_be = t.be; ls_req = 1'b1;
        end else begin
            if_addr = t.addr; if_req = 1'b1;
        end
        while (!got && waited < 60) begin
            @(negedge clock);
            if (t.is_ls ? ls_ready : if_ready) got = 1;
            else begin
                waited++;
                @(posedge clock); #1;
            end
        end
        if (!got) begin
            chk(t.is_ls ? "ls_ready_timeout" : "if_ready_timeout", 64'd0, 64'd1);
            if (t.is_ls) ls_req = 1'b0; else if_req = 1'b0;
            return;
        end
        acc_cyc = cyc;
        chk(t.is_ls ? "grant_exclusive_ls" : "grant_exclusive_if",
            64'(t.is_ls ? if_ready : ls_ready), 64'd0);
        chk("idle_mem_strobes", 64'({mem_en, mem_we, mem_be}), 64'd0);
        chk("mem_addr_hold", 64'(mem_addr), 64'(last_addr));
        if (!(t.is_ls && t.we)) begin
            if (t.is_ls) ls_exp_q.push_back({32'(acc_cyc + RESP_LAT), t.exp_rdata});
            else         if_exp_q.push_back({32'(acc_cyc + RESP_LAT), t.exp_rdata});
        end
        @(posedge clock); #1;
        if (t.is_ls) ls_req = 1'b0; else if_req = 1'b0;
        @(negedge clock);
        chk("issue_mem_en", 64'(mem_en), 64'd1);
        chk("issue_mem_we", 64'(mem_we), 64'(t.is_ls && t.we));
        chk("issue_mem_addr", 64'(mem_addr), 64'(t.addr));
        chk("issue_mem_be", 64'(mem_be), t.is_ls ? 64'(t.be) : 64'hF);
        if (t.is_ls && t.we) chk("issue_mem_wdata", 64'(mem_wdata), 64'(t.wdata));
        chk("issue_busy", 64'(busy), 64'd1);
        last_addr = t.addr;
        @(posedge clock); #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!busy) begin done = 1; break; end
        end
        if (!done) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
    endtask

    // ---------------- test ----------------
    txn_t vec [8];
    int   ls_acc [6];

    initial begin
        int a0, a1, w0, w1, t0, if_acc, n_before, first_idle;
        bit found;

        vec[0] = mk(0, 0, 32'h0000_0010, 32'h0, 4'h0);
        vec[1] = mk(1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        vec[2] = mk(1, 0, 32'h0000_0080, 32'h0, 4'hF);
        vec[3] = mk(0, 0, 32'h0000_1234, 32'h0, 4'h0);
        for (int i = 4; i < 8; i++)
            vec[i] = mk(1'($urandom_range(0, 1)) | 1'(i == 4), 1'($urandom_range(0, 1)),
                        $urandom & 32'hFFFC, $urandom, 4'($urandom_range(1, 15)));

        // reset
        reset = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctrl", 64'({if_ready, if_rvalid, ls_ready, ls_rvalid, mem_en, mem_we,
                               mem_be, busy, dbg_state, dbg_starve_cnt}), 64'd0);
        chk("reset_if_rdata", 64'(if_rdata), 64'd0);
        chk("reset_ls_rdata", 64'(ls_rdata), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clock); #1; end

        // single fetch: ready at once, idle again at A+OCC
        do_txn(vec[0], a0, w0);
        chk("fetch_wait", 64'(w0), 64'd0);
        first_idle = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) begin first_idle = cyc; break; end
        end
        chk("fetch_busy_end", 64'(first_idle - a0), 64'(OCC));
        @(posedge clock); #1;

        // store then back-to-back load: accepted two cycles after the store
        do_txn(vec[1], a0, w0);
        do_txn(vec[2], a1, w1);
        chk("store_next_wait", 64'(w1), 64'd0);
        chk("store_next_gap", 64'(a1 - a0), 64'd2);
        wait_idle();

        // collision: LS wins, IF granted when the load is done
        t0 = cyc;
        fork
            do_txn(mk(1, 0, 32'h80, 32'h0, 4'hF), a0, w0);
            do_txn(mk(0, 0, 32'h84, 32'h0, 4'h0), a1, w1);
        join
        chk("collision_ls_cycle", 64'(a0 - t0), 64'd0);
        chk("collision_if_cycle", 64'(a1 - t0), 64'(OCC));
        wait_idle();

        // table vectors
        for (int i = 3; i < 8; i++) begin
            do_txn(vec[i], a0, w0);
        end
        wait_idle();

        // starvation: back-to-back stores against a waiting fetch
        t0 = cyc;
        fork
            do_txn(mk(0, 0, 32'h200, 32'h0, 4'h0), if_acc, w0);
            begin
                for (int i = 0; i < 6; i++) begin
                    int w;
                    do_txn(mk(1, 1, 32'h400 + 32'(i * 4), $urandom, 4'hF), ls_acc[i], w);
                end
            end
            begin
                found = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clock);
                    if (if_ready) begin found = 1; break; end
                end
                chk("starve_if_ready_seen", 64'(found), 64'd1);
                if (found) begin
                    chk("starve_cnt_at_limit", 64'(dbg_starve_cnt), 64'(SL));
                    @(negedge clock);
                    chk("starve_cnt_cleared", 64'(dbg_starve_cnt), 64'd0);
                end
            end
        join
        n_before = 0;
        for (int i = 0; i < 6; i++) if (ls_acc[i] < if_acc) n_before++;
        chk("starve_ls_grants", 64'(n_before), 64'(SL));
        chk("starve_if_cycle", 64'(if_acc - t0), 64'(2 * SL));
        chk("starve_ls_resume", 64'(ls_acc[SL] - if_acc), 64'(OCC));
        wait_idle();

        // reset during WAIT abandons the fetch
        if_addr = 32'h300; if_req = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (if_ready) begin found = 1; break; end
            @(posedge clock); #1;
        end
        chk("rst_fetch_accept", 64'(found), 64'd1);
        @(posedge clock); #1;
        if_req = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_in_wait", 64'(dbg_state), 64'd2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_ctrl", 64'({if_ready, if_rvalid, ls_ready, ls_rvalid, mem_en, mem_we,
                                 mem_be, busy, dbg_state, dbg_starve_cnt}), 64'd0);
        chk("rst_mid_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
        last_addr = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("rst_no_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        end
        @(posedge clock); #1;
        do_txn(mk(0, 0, 32'h304, 32'h0, 4'h0), a0, w0);
        chk("rst_fresh_wait", 64'(w0), 64'd0);
        wait_idle();

        repeat (4) begin @(posedge clock); #1; end
        chk("if_queue_drained", 64'(if_exp_q.size()), 64'd0);
        chk("ls_queue_drained", 64'(ls_exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous instruction/data memory between the processor's instruction-fetch (IF) port and its load/store (LS) port. Grants one transaction at a time and drives the memory port with registered address, data and enable. Returns read data to the granted requester after a fixed latency. Sits between the PROCESSOR core datapath and the unified memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; must be 1 or more
STARVE_LIMIT, 4, maximum number of consecutive LS grants while IF is waiting; must be 1 or more

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request; held stable until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetch data
ls_req  in  1  load/store request; held stable until ls_ready
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_be  in  DATA_W/8  store byte enables
ls_ready  out  1  load/store accepted this cycle
ls_rvalid  out  1  one-cycle pulse, loads only
ls_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- States:
  - IDLE: accepts a new request.
  - ISSUE: one cycle; mem_en=1.
  - WAIT: MEM_LATENCY cycles, tracked by a down-counter.
  - RESP: one cycle; rvalid pulse.
- Grant is combinational and only in IDLE:
  - force_if = (starve_cnt == STARVE_LIMIT) && if_req.
  - ls_ready = IDLE && ls_req && !force_if.
  - if_ready = IDLE && if_req && (!ls_req || force_if).
  - if_ready and ls_ready are never both high.
- Acceptance at cycle A:
  - Owner, address, we, wdata and be are registered.
  - IF requests are always reads, with mem_we=0 and mem_be all-ones.
  - Next state is ISSUE.
- Cycle A+1 (ISSUE): mem_en=1; mem_we/addr/wdata/be come from the registered copy.
  - Store: the transaction completes. Next state is IDLE, so a new grant is possible at A+2. No rvalid is generated.
  - Read: next state is WAIT.
- WAIT, cycles A+2 .. A+1+MEM_LATENCY: on the last WAIT cycle, mem_rdata is captured into the owner's rdata register. Next state is RESP.
- Cycle A+2+MEM_LATENCY (RESP): the owner's rvalid is 1 for exactly one cycle. Next state is IDLE.
  - Read occupancy is MEM_LATENCY+3 cycles per access.
- rdata registers hold their value until the next capture.
- Outside ISSUE: mem_en=0, mem_we=0, mem_be=0. mem_addr and mem_wdata hold their last value.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments on an LS grant while if_req=1.
  - Clears on an IF grant, or in any IDLE cycle with if_req=0.
  - Saturates at STARVE_LIMIT.
- Requests arriving outside IDLE are not acknowledged; they stay pending until IDLE.
- Reset: state IDLE, starve_cnt 0.
  - All outputs 0, including rdata, mem_addr, mem_wdata and busy.
  - Reset mid-transaction abandons the access: no rvalid is produced afterwards, and mem_en is 0 in the cycle after reset is sampled.
- Simultaneous if_req and ls_req with starve_cnt below the limit: LS wins.

Optional Feature:
MEM_ARB_BYPASS_EN
- Defined:
  - RESP state is removed.
  - rvalid is asserted in the last WAIT cycle (A+1+MEM_LATENCY).
  - The owner's rdata is driven combinationally from mem_rdata in that cycle and from the register otherwise.
  - State returns to IDLE one cycle earlier; read occupancy is MEM_LATENCY+2.
- Undefined: fully registered response, exactly as described in Behaviour.

Test Plan:
(MEM_LATENCY=2, STARVE_LIMIT=4, macro undefined unless stated)
- Single fetch: reset released, if_req=1 with if_addr=0x10 at cycle 0; memory returns 0x00500093.
  - if_ready at cycle 0; mem_en with mem_addr=0x10 at cycle 1; if_rvalid with if_rdata=0x00500093 at cycle 4; busy high cycles 1-4.
- Store: ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF, ls_be=0xF at cycle 0.
  - mem_en=mem_we=1 with that data at cycle 1; no ls_rvalid; ls_ready possible again at cycle 2.
- Collision: if_req and ls_req (load 0x80) both rise at cycle 0.
  - ls_ready at cycle 0; if_ready at cycle 5; ls_rvalid at cycle 4.
- Starvation: ls_req held high for back-to-back stores while if_req=1 continuously.
  - Exactly 4 LS grants, then if_ready; starve_cnt returns to 0.
- Reset mid-read: reset asserted during WAIT, one cycle after ISSUE.
  - No rvalid at all; all outputs 0 the next cycle; a fresh fetch afterwards completes normally.
- Bypass: with MEM_ARB_BYPASS_EN defined, repeat the single-fetch test.
  - if_rvalid at cycle 3 with correct data; next if_ready possible at cycle 4.
